// File: rtl/load_return_unit_pkg.sv
// Shared types for the memory-stage load engine: size encodings and the
// per-entry record kept for every outstanding load.
package load_pkg;

    localparam int DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef struct packed {
        logic [4:0] dest;
        logic [1:0] off;
        size_e      size;
        logic       sgn;
        logic       killed;
    } load_entry_t;

endpackage

// File: rtl/load_return_unit_if.sv
// Load-engine signal bundle: pipe3 request, data-memory bus, write-back and
// the pending-destination view used by the pipe2 hazard logic.
interface load_return_unit_if #(
    parameter int DEPTH = 2
);
    logic                 ld_valid;
    logic                 ld_ready;
    logic [31:0]          ld_addr;
    logic [1:0]           ld_size;
    logic                 ld_signed;
    logic [4:0]           ld_dest;
    logic                 flush;

    logic                 data_req;
    logic [31:0]          data_addr;
    logic [1:0]           data_size;
    logic                 data_addr_ok;
    logic [31:0]          data_rdata;
    logic                 data_data_ok;

    logic                 wb_valid;
    logic [4:0]           wb_dest;
    logic [31:0]          wb_data;

    logic [DEPTH-1:0]     pend_valid;
    logic [5*DEPTH-1:0]   pend_dest;
    logic                 busy;

    // master: the surrounding pipeline and memory bus
    modport master (
        output ld_valid, ld_addr, ld_size, ld_signed, ld_dest, flush,
        output data_addr_ok, data_rdata, data_data_ok,
        input  ld_ready, data_req, data_addr, data_size,
        input  wb_valid, wb_dest, wb_data, pend_valid, pend_dest, busy
    );

    // slave: the load engine itself
    modport slave (
        input  ld_valid, ld_addr, ld_size, ld_signed, ld_dest, flush,
        input  data_addr_ok, data_rdata, data_data_ok,
        output ld_ready, data_req, data_addr, data_size,
        output wb_valid, wb_dest, wb_data, pend_valid, pend_dest, busy
    );

endinterface

// File: rtl/load_return_unit_extend.sv
// Combinational lane select and sign/zero extension of a returned data word.
module load_extend
    import load_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (off)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = off[1] ? rdata[31:16] : rdata[15:0];

        // reserved size falls through as a word; it never reaches here legally
        case (size)
            SZ_BYTE: data = {{24{sgn & byte_lane[7]}}, byte_lane};
            SZ_HALF: data = {{16{sgn & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_return_unit.sv
// In-order load engine: queues bus requests, kills them on flush, and
// registers the aligned write-back when each beat returns.
module load_return_unit
    import load_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    load_return_unit_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       head;
    logic [AW:0]       tail;
    logic [AW-1:0]     head_idx;
    logic [AW-1:0]     tail_idx;
    logic [DEPTH-1:0]  occ;
    load_entry_t       q [DEPTH];
    load_entry_t       head_e;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              wb_valid_q;
    logic [4:0]        wb_dest_q;
    logic [31:0]       wb_data_q;
    logic [31:0]       ext_data;

    assign head_idx = head[AW-1:0];
    assign tail_idx = tail[AW-1:0];
    assign full     = (head_idx == tail_idx) && (head[AW] != tail[AW]);
    assign empty    = (head == tail);
    assign head_e   = q[head_idx];

    assign bus.data_req  = bus.ld_valid & ~full & ~bus.flush;
    assign bus.ld_ready  = bus.data_req & bus.data_addr_ok;
    assign bus.data_addr = {bus.ld_addr[31:2], 2'b00};
    assign bus.data_size = bus.ld_size;

    assign push = bus.ld_ready;
    // beats with nothing outstanding are dropped, see the assertion below
    assign pop  = bus.data_data_ok & ~empty;

    load_extend u_extend (
        .rdata (bus.data_rdata),
        .off   (head_e.off),
        .size  (head_e.size),
        .sgn   (head_e.sgn),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            if (push) begin
                q[tail_idx] <= '{dest:   bus.ld_dest,
                                 off:    bus.ld_addr[1:0],
                                 size:   size_e'(bus.ld_size),
                                 sgn:    bus.ld_signed,
                                 killed: 1'b0};
                occ[tail_idx] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                occ[head_idx] <= 1'b0;
                head          <= head + 1'b1;
            end
            // flush and push are exclusive, so kill never races a fresh entry
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (occ[i]) begin
                        q[i].killed <= 1'b1;
                    end
                end
            end
            wb_valid_q <= pop & ~head_e.killed & ~bus.flush;
            if (pop && !head_e.killed && !bus.flush) begin
                wb_dest_q <= head_e.dest;
                wb_data_q <= ext_data;
            end
        end
    end

    always_comb begin
        bus.pend_valid = '0;
        bus.pend_dest  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.pend_valid[i]      = occ[i] & ~q[i].killed;
            bus.pend_dest[5*i +: 5] = q[i].dest;
        end
    end

    assign bus.busy     = ~empty;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_dest  = wb_dest_q;
    assign bus.wb_data  = wb_data_q;

    stray_data_ok : assert property (@(posedge clk) disable iff (!resetn)
        !(bus.data_data_ok && empty));

endmodule

// File: tb/tb_load_return_unit.sv
// Self-checking bench for load_return_unit: directed scenarios plus random
// traffic against a slot-level reference model of the load queue.
module tb_load_return_unit;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    load_return_unit_if #(.DEPTH(DEPTH)) lif();

    load_return_unit #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (lif)
    );

    always #5 clk = ~clk;

    // reference model: slots indexed like the queue, plain integer pointers
    int          m_occ    [DEPTH];
    int          m_killed [DEPTH];
    int          m_dest   [DEPTH];
    int          m_off    [DEPTH];
    int          m_size   [DEPTH];
    int          m_sgn    [DEPTH];
    int          m_head, m_tail, m_count;
    logic        exp_wbv;
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(logic [31:0] rd, int off, int sz, int sg);
        logic [31:0] v;
        if (sz == 0) begin
            v = (rd >> (8 * off)) & 32'h0000_00FF;
            if (sg != 0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
            if (sg != 0 && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_occ[i] = 0; m_killed[i] = 0; m_dest[i] = 0;
            m_off[i] = 0; m_size[i] = 0; m_sgn[i] = 0;
        end
        m_head = 0; m_tail = 0; m_count = 0;
        exp_wbv = 1'b0; exp_dest = '0; exp_data = '0;
    endtask

    task automatic check_regs();
        logic [DEPTH-1:0]   pv;
        logic [5*DEPTH-1:0] pd_mask;
        logic [5*DEPTH-1:0] pd_exp;
        pv = '0; pd_mask = '0; pd_exp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_occ[i] != 0 && m_killed[i] == 0) begin
                pv[i] = 1'b1;
                pd_mask[5*i +: 5] = 5'h1F;
                pd_exp[5*i +: 5]  = 5'(m_dest[i]);
            end
        end
        chk("wb_valid", 32'(lif.wb_valid), 32'(exp_wbv));
        chk("wb_dest", 32'(lif.wb_dest), 32'(exp_dest));
        chk("wb_data", lif.wb_data, exp_data);
        chk("pend_valid", 32'(lif.pend_valid), 32'(pv));
        chk("pend_dest", 32'(lif.pend_dest & pd_mask), 32'(pd_exp));
        chk("busy", 32'(lif.busy), 32'(m_count != 0));
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [1:0] sz,
                        input logic sg, input logic [4:0] d, input logic fl,
                        input logic aok, input logic dok, input logic [31:0] rd);
        logic fire, pop, room;
        @(negedge clk);
        lif.ld_valid = v; lif.ld_addr = a; lif.ld_size = sz; lif.ld_signed = sg;
        lif.ld_dest = d; lif.flush = fl; lif.data_addr_ok = aok;
        lif.data_data_ok = dok; lif.data_rdata = rd;
        #1;
        room = (m_count < DEPTH);
        chk("data_req", 32'(lif.data_req), 32'(v && room && !fl));
        chk("ld_ready", 32'(lif.ld_ready), 32'(v && room && !fl && aok));
        if (v) begin
            chk("data_addr", lif.data_addr, a & 32'hFFFF_FFFC);
            chk("data_size", 32'(lif.data_size), 32'(sz));
        end
        fire = v && room && !fl && aok;
        pop  = dok && (m_count > 0);
        exp_wbv = 1'b0;
        if (pop) begin
            if (m_killed[m_head] == 0 && !fl) begin
                exp_wbv  = 1'b1;
                exp_dest = 5'(m_dest[m_head]);
                exp_data = ref_ext(rd, m_off[m_head], m_size[m_head], m_sgn[m_head]);
            end
            m_occ[m_head] = 0;
            m_head = (m_head + 1) % DEPTH;
            m_count--;
        end
        if (fl) begin
            for (int i = 0; i < DEPTH; i++) if (m_occ[i] != 0) m_killed[i] = 1;
        end
        if (fire) begin
            m_occ[m_tail] = 1; m_killed[m_tail] = 0; m_dest[m_tail] = int'(d);
            m_off[m_tail] = int'(a[1:0]); m_size[m_tail] = int'(sz); m_sgn[m_tail] = int'(sg);
            m_tail = (m_tail + 1) % DEPTH;
            m_count++;
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic        v, fl, aok, dok;
        model_reset();
        lif.ld_valid = 1'b0; lif.ld_addr = '0; lif.ld_size = '0; lif.ld_signed = 1'b0;
        lif.ld_dest = '0; lif.flush = 1'b0; lif.data_addr_ok = 1'b0;
        lif.data_data_ok = 1'b0; lif.data_rdata = '0;
        #12;
        check_regs();
        @(negedge clk);
        resetn = 1'b1;

        // single signed byte, return three cycles after the fire
        step(1'b1, 32'h0000_1003, 2'd0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("lb_pend0", 32'(lif.pend_valid[0]), 32'd1);
        idle();
        idle();
        chk("lb_no_wb_yet", 32'(lif.wb_valid), 32'd0);
        step(1'b0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h80FF_FF00);
        chk("lb_wb_data", lif.wb_data, 32'hFFFF_FF80);
        chk("lb_wb_dest", 32'(lif.wb_dest), 32'd5);
        idle();

        // unsigned upper half, then a word
        step(1'b1, 32'h0000_2002, 2'd1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h0000_3000, 2'd2, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 32'hBEEF_1234);
        chk("lh_wb_data", lif.wb_data, 32'h0000_BEEF);
        step(1'b0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        chk("lw_wb_data", lif.wb_data, 32'hCAFE_F00D);

        // fill, third refused, push refused in the cycle of the first pop
        step(1'b1, 32'h100, 2'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h104, 2'd2, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h108, 2'd2, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h108, 2'd2, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, 32'h1111_1111);
        chk("fill_first_dest", 32'(lif.wb_dest), 32'd3);
        step(1'b0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h2222_2222);
        chk("fill_second_dest", 32'(lif.wb_dest), 32'd4);

        // flush with two outstanding
        step(1'b1, 32'h200, 2'd2, 1'b0, 5'd10, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h204, 2'd2, 1'b0, 5'd11, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h208, 2'd2, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush_pend", 32'(lif.pend_valid), 32'd0);
        chk("flush_busy", 32'(lif.busy), 32'd1);
        step(1'b0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h3333_3333);
        step(1'b0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h4444_4444);
        chk("flush_drained", 32'(lif.busy), 32'd0);

        // simultaneous issue and return
        step(1'b1, 32'h300, 2'd2, 1'b0, 5'd13, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h304, 2'd2, 1'b0, 5'd14, 1'b0, 1'b1, 1'b1, 32'h5555_5555);
        chk("swap_dest", 32'(lif.wb_dest), 32'd13);
        step(1'b0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h6666_6666);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            sz  = 2'($urandom_range(0, 2));
            a   = $urandom;
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            fl  = ($urandom_range(0, 19) == 0);
            aok = ($urandom_range(0, 3) != 0);
            dok = (m_count > 0) && ($urandom_range(0, 1) == 1);
            step(v, a, sz, 1'($urandom), 5'($urandom), fl, aok, dok, $urandom);
        end

        // asynchronous reset with one load outstanding
        step(1'b1, 32'h400, 2'd0, 1'b1, 5'd21, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        lif.ld_valid = 1'b1; lif.flush = 1'b0; lif.data_addr_ok = 1'b0; lif.data_data_ok = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_regs();
        chk("rst_data_req", 32'(lif.data_req), 32'd1);
        @(negedge clk);
        lif.ld_valid = 1'b0;
        resetn = 1'b1;
        idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/load_return_unit.md
# load_return_unit

Memory-stage load engine that turns pipe3 load requests into data-memory transactions over the SRAM-like req/addr_ok/data_ok bus. It keeps an in-order queue of outstanding loads, aligns and extends the returned data, and issues a registered write-back. It also publishes the destination register of every in-flight load so that the pipe2 hazard logic can stall consumers until the data returns.

## Interface
Parameters:
- DEPTH, 2, maximum number of outstanding loads; power of two, at least 2.

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ld_valid  in  1  pipe3 presents a load.
- ld_ready  out  1  load accepted this cycle when ld_valid is also high.
- ld_addr  in  32  byte address.
- ld_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved.
- ld_signed  in  1  sign-extend when 1, zero-extend when 0.
- ld_dest  in  5  destination GPR.
- flush  in  1  kill every outstanding load and block issue this cycle.
- data_req  out  1  bus request.
- data_addr  out  32  equals ld_addr with bits [1:0] forced to 0.
- data_size  out  2  equals ld_size.
- data_addr_ok  in  1  bus accepts the address.
- data_rdata  in  32  return data.
- data_data_ok  in  1  return beat.
- wb_valid  out  1  write-back strobe.
- wb_dest  out  5  write-back register.
- wb_data  out  32  aligned, extended data.
- pend_valid  out  DEPTH  per entry: live, i.e. not killed and not yet returned.
- pend_dest  out  5*DEPTH  per-entry destination; entry i occupies bits [5i+4:5i].
- busy  out  1  queue non-empty, killed entries included.

## Operation
- Issue path:
  - data_req = ld_valid & ~full & ~flush.
  - ld_ready = data_req & data_addr_ok. Ready depends on valid; the upstream stage must not wait on ready before asserting valid.
  - On a fire, push entry {dest, addr[1:0], size, signed, killed=0} at the tail.
- Return path, on data_data_ok:
  - Pop the head entry.
  - If the head is not killed: wb_valid=1, wb_dest=head.dest, wb_data=extend(rdata) on the next cycle.
  - If the head is killed: the beat is consumed and wb_valid stays 0.
- Extension rules, with off = stored addr[1:0]:
  - byte: rdata[8*off+7:8*off].
  - half: rdata[16*off[1]+15:16*off[1]].
  - word: rdata.
  - Result is extended to 32 bits by ld_signed. Misalignment is trapped upstream and is not checked here.
- Flush: every valid entry gets killed=1 at the clock edge. The queue still drains via data_ok, because the bus returns every accepted request.
- Pointers: head and tail use log2(DEPTH)+1 bits. Full is when the index bits match and the wrap bits differ; empty is when both are equal.
- Simultaneous push and pop are both allowed. A push is never permitted while full, even if a pop happens in the same cycle (no bypass).
- data_data_ok while the queue is empty is a protocol error: ignore it (no pop, no write-back) and assert in simulation.
- pend_valid[i] is high when the entry is occupied and not killed. This lets the hazard logic compare pend_dest directly against the pipe2 source registers.

## Timing
- Reset values:
  - data_req follows its inputs combinationally.
  - ld_ready follows its inputs combinationally.
  - wb_valid=0, wb_dest=0, wb_data=0.
  - pend_valid=0, busy=0; pointers are 0 and all killed bits are 0.
- A fire at cycle T makes pend_valid for the new entry visible at T+1.
- Earliest return is data_ok at T+1, which gives wb_valid at T+2. Load-to-write-back latency is (data_ok cycle) + 1.
- wb_valid is a one-cycle pulse per live return. Back-to-back data_ok beats produce back-to-back write-backs.
- A flush at cycle F blocks issue in F. From F+1, pend_valid=0 for all entries present at F. An entry that pops in F with data_ok produces no write-back.
- Asserting resetn low mid-transaction clears all state immediately. The bus is expected to be reset in the same cycle.

## Structure
- Package load_pkg holds:
  - The size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - A load entry record type: dest[4:0], off[1:0], size[1:0], sgn, killed.
  - The default DEPTH.
- Sub-module load_extend: purely combinational align and extend, taking (rdata, off, size, sgn) and producing data. It is reused by any future uncached-load path.
- The top level holds the entry array, pointers, kill logic, and the write-back register.

## Test plan
- Single lb: addr=0x1003, signed, dest=5, data_addr_ok=1 at T, data_data_ok at T+3 with rdata=0x80FF_FF00 -> wb_valid at T+4, wb_dest=5, wb_data=0xFFFF_FF80; pend_valid[0] high T+1..T+3.
- Half, unsigned: addr=0x2002, rdata=0xBEEF_1234 -> wb_data=0x0000_BEEF; word: rdata passes through unchanged.
- Fill DEPTH=2 with dest=3 then dest=4 while holding data_ok low -> ld_ready=0 and data_req=0 for a third load. Return order is dest 3 then dest 4; a push in the same cycle as the first pop is still refused.
- Flush with 2 loads outstanding -> pend_valid=0 next cycle, busy stays 1. Two data_ok beats produce no wb_valid, after which busy=0.
- Issue and return in the same cycle (queue holds 1, data_ok plus a new fire) -> count stays 1 and wb_valid fires for the older entry.
- resetn pulsed low with 1 load outstanding -> all outputs return to their reset values asynchronously. A stray data_ok afterwards produces no write-back and fires the assertion.
